// File: rtl/obi_spi_flash_reader.sv
// rtl/obi_spi_flash_reader.sv - OBI read-only window onto a SPI NOR flash
// Each granted word read becomes one SPI READ (0x03) transaction, mode 0, MSB first.
module obi_spi_flash_reader #(
  parameter logic [31:0] FLASH_BASE_ADDR = 32'h2000_0000,
  parameter int          CLK_DIV         = 2,
  parameter int          CS_IDLE_CYCLES  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        illegal_write_o,
  output logic        busy_o,
  output logic        spi_csn_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_CSWAIT = 2'd3;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'(CS_IDLE_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] div_cnt;
  logic [15:0] wait_cnt;
  logic [5:0]  bit_cnt;
  logic [63:0] tx_sh;
  logic [31:0] rx_sh;
  logic [31:0] offset;
  logic [23:0] flash_addr;
  logic [63:0] tx_load;
  logic        unused_inputs;

  assign offset     = addr_i - FLASH_BASE_ADDR;
  assign flash_addr = {offset[23:2], 2'b00};
  assign tx_load    = {8'h03, flash_addr, 32'h0};

  // The write error response occupies the cycle after the grant, so hold off a new grant then.
  assign gnt_o  = req_i & (state == ST_IDLE) & ~illegal_write_o;
  assign busy_o = (state != ST_IDLE);

  assign unused_inputs = ^{be_i, wdata_i, offset[31:24], offset[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= ST_IDLE;
      div_cnt         <= '0;
      wait_cnt        <= '0;
      bit_cnt         <= '0;
      tx_sh           <= '0;
      rx_sh           <= '0;
      rvalid_o        <= 1'b0;
      rdata_o         <= '0;
      illegal_write_o <= 1'b0;
      spi_csn_o       <= 1'b1;
      spi_sck_o       <= 1'b0;
      spi_mosi_o      <= 1'b0;
    end else begin
      rvalid_o        <= 1'b0;
      illegal_write_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_i && gnt_o) begin
            if (we_i) begin
              rvalid_o        <= 1'b1;
              rdata_o         <= '0;
              illegal_write_o <= 1'b1;
            end else begin
              state      <= ST_SHIFT;
              spi_csn_o  <= 1'b0;
              spi_sck_o  <= 1'b0;
              tx_sh      <= tx_load;
              spi_mosi_o <= tx_load[63];
              div_cnt    <= '0;
              bit_cnt    <= '0;
            end
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!spi_sck_o) begin
              spi_sck_o <= 1'b1;
              rx_sh     <= {rx_sh[30:0], spi_miso_i};
            end else if (bit_cnt == 6'd63) begin
              // Only the last 32 sampled bits survive in rx_sh; first wire byte lands in [7:0].
              spi_sck_o  <= 1'b0;
              spi_csn_o  <= 1'b1;
              spi_mosi_o <= 1'b0;
              state      <= ST_RESP;
              rvalid_o   <= 1'b1;
              rdata_o    <= {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
            end else begin
              spi_sck_o  <= 1'b0;
              bit_cnt    <= bit_cnt + 6'd1;
              tx_sh      <= {tx_sh[62:0], 1'b0};
              spi_mosi_o <= tx_sh[62];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          state    <= ST_CSWAIT;
          wait_cnt <= '0;
        end
        ST_CSWAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
